// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state encodings shared by the multicycle ALU.
package alu_pkg;
    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_ADD  = 3'd2,
        OP_MULU = 3'd3,
        OP_DIVU = 3'd4,
        OP_RSVD = 3'd5,
        OP_SUB  = 3'd6,
        OP_SLTU = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;
endpackage

// File: rtl/alu_iter_core.sv
// alu_iter_core: one-bit-per-cycle unsigned shift-add multiplier / restoring divider.
// lo_nxt/hi_nxt are the values after the current iteration, so the final result is usable on the last cycle.
module alu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             run,
    input  logic             div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo_nxt,
    output logic [WIDTH-1:0] hi_nxt,
    output logic             last
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] opnd;
    logic             div_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            lo    <= '0;
            hi    <= '0;
            opnd  <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            cnt   <= '0;
            lo    <= a;
            hi    <= '0;
            opnd  <= b;
            div_q <= div;
        end else if (run) begin
            cnt <= cnt + CW'(1);
            lo  <= lo_nxt;
            hi  <= hi_nxt;
        end
    end

    // hi holds the partial product (mul) or partial remainder (div); diff[WIDTH] is the borrow
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        hi_nxt  = div_q ? (diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
        lo_nxt  = div_q ? {lo[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], lo[WIDTH-1:1]};
    end

    assign last = cnt == CW'(WIDTH - 1);
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: ALU with single-cycle logic/add/sub ops and iterative unsigned mul/div.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Hi,
    output logic             Zero,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             DivZero
);
    state_e           state;
    state_e           state_nxt;
    logic             iter;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] core_lo;
    logic [WIDTH-1:0] core_hi;
    logic [WIDTH-1:0] s_res;
    logic [WIDTH-1:0] s_hi;
    logic [WIDTH:0]   add;
    logic [WIDTH:0]   sub;
    logic             s_c;
    logic             s_v;
    logic             s_dz;

    alu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (Clk),
        .rst_n  (Rst_n),
        .load   (accept && iter),
        .run    (state == S_CALC),
        .div    (Op == OP_DIVU),
        .a      (A),
        .b      (B),
        .lo_nxt (core_lo),
        .hi_nxt (core_hi),
        .last   (last)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= S_IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        iter      = (Op == OP_MULU) || (Op == OP_DIVU && B != '0);
        accept    = state == S_IDLE && Start;
        state_nxt = state;
        case (state)
            S_IDLE:  if (Start && iter) state_nxt = S_CALC;
                     else if (Start) state_nxt = S_DONE;
            S_CALC:  if (last) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Divide by zero bypasses the iterative core and finishes like a single-cycle op
    always_comb begin
        add   = {1'b0, A} + {1'b0, B};
        sub   = {1'b0, A} - {1'b0, B};
        s_res = '0;
        s_hi  = '0;
        s_c   = 1'b0;
        s_v   = 1'b0;
        s_dz  = 1'b0;
        case (Op)
            OP_AND:  s_res = A & B;
            OP_OR:   s_res = A | B;
            OP_ADD: begin
                s_res = add[WIDTH-1:0];
                s_c   = add[WIDTH];
                s_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                s_res = sub[WIDTH-1:0];
                s_c   = sub[WIDTH];
                s_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLTU: s_res = WIDTH'(sub[WIDTH]);
            OP_DIVU: begin
                s_res = '1;
                s_hi  = A;
                s_dz  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Result   <= '0;
            Hi       <= '0;
            CarryOut <= 1'b0;
            Overflow <= 1'b0;
            DivZero  <= 1'b0;
        end else if (accept && !iter) begin
            Result   <= s_res;
            Hi       <= s_hi;
            CarryOut <= s_c;
            Overflow <= s_v;
            DivZero  <= s_dz;
        end else if (state == S_CALC && last) begin
            Result   <= core_lo;
            Hi       <= core_hi;
            CarryOut <= 1'b0;
            Overflow <= 1'b0;
            DivZero  <= 1'b0;
        end
    end

    assign Busy = state != S_IDLE;
    assign Done = state == S_DONE;
    assign Zero = Result == '0;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed and randomized checks of alu_multicycle against a cycle-level behavioural model.
module tb_alu_multicycle;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, zero, cout, ovf, dz;
    logic [31:0] res, hi;

    logic        start8 = 1'b0;
    logic [2:0]  op8 = 3'd0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8, zero8, cout8, ovf8, dz8;
    logic [7:0]  res8, hi8;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(32)) dut (
        .Clk(clk), .Rst_n(rst_n), .Start(start), .Op(op), .A(a), .B(b),
        .Busy(busy), .Done(done), .Result(res), .Hi(hi), .Zero(zero),
        .CarryOut(cout), .Overflow(ovf), .DivZero(dz)
    );

    alu_multicycle #(.WIDTH(8)) dut8 (
        .Clk(clk), .Rst_n(rst_n), .Start(start8), .Op(op8), .A(a8), .B(b8),
        .Busy(busy8), .Done(done8), .Result(res8), .Hi(hi8), .Zero(zero8),
        .CarryOut(cout8), .Overflow(ovf8), .DivZero(dz8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: p counts cycles since acceptance, Done expected when p reaches lat
    int          p = 0;
    int          lat = 1;
    logic [31:0] m_res = '0, m_hi = '0, q_res, q_hi;
    logic        m_c = 1'b0, m_v = 1'b0, m_dz = 1'b0, q_c, q_v, q_dz;

    task automatic model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, sr;
        logic [63:0] prod;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q_res = '0; q_hi = '0; q_c = 1'b0; q_v = 1'b0; q_dz = 1'b0; lat = 1;
        case (o)
            3'd0: q_res = x & y;
            3'd1: q_res = x | y;
            3'd2: begin
                q_res = x + y;
                q_c = ({32'b0, x} + {32'b0, y}) > 64'hFFFF_FFFF;
                sr = sx + sy;
                q_v = sr != longint'($signed(sr[31:0]));
            end
            3'd3: begin
                prod = {32'b0, x} * {32'b0, y};
                q_res = prod[31:0];
                q_hi = prod[63:32];
                lat = 33;
            end
            3'd4: begin
                if (y == 0) begin
                    q_res = '1; q_hi = x; q_dz = 1'b1;
                end else begin
                    q_res = x / y; q_hi = x % y; lat = 33;
                end
            end
            3'd6: begin
                q_res = x - y;
                q_c = x < y;
                sr = sx - sy;
                q_v = sr != longint'($signed(sr[31:0]));
            end
            3'd7: q_res = 32'(x < y);
            default: ;
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p = 0; m_res = '0; m_hi = '0; m_c = 1'b0; m_v = 1'b0; m_dz = 1'b0;
        end else if (p > 0) p = (p == lat) ? 0 : p + 1;
        else if (start) begin
            model_op(op, a, b);
            p = 1;
        end
        if (p > 0 && p == lat) begin
            m_res = q_res; m_hi = q_hi; m_c = q_c; m_v = q_v; m_dz = q_dz;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, p > 0);
            chk("done", done, p > 0 && p == lat);
            chk("result", res, m_res);
            chk("hi", hi, m_hi);
            chk("zero", zero, m_res == 0);
            chk("carry", cout, m_c);
            chk("overflow", ovf, m_v);
            chk("divzero", dz, m_dz);
        end
    end

    task automatic start_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(input bit w8, output int n);
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (w8 ? done8 : done) begin
                n = i;
                break;
            end
        end
    endtask

    function automatic logic [31:0] rnd();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom % 16);
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_result", res, 0);
        chk("rst_zero", zero, 1);
        chk("rst_busy", busy, 0);

        @(posedge clk); #1;
        start8 = 1'b1; op8 = OP_MULU; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        wait_done(1'b1, n);
        chk("w8_mul_lat", n, 9);
        chk("w8_mul_prod", {hi8, res8}, 16'hFE01);
        @(posedge clk); #1;
        start8 = 1'b1; op8 = OP_DIVU; a8 = 8'd200; b8 = 8'd7;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done(1'b1, n);
        chk("w8_div_lat", n, 9);
        chk("w8_div_q_r", {hi8, res8}, {8'd4, 8'd28});

        start_op(OP_ADD, 32'hFFFF_FFFF, 32'h1);
        wait_done(1'b0, n);
        chk("add_lat", n, 1);
        chk("add_res", res, 0);
        chk("add_zero", zero, 1);
        chk("add_carry", cout, 1);
        chk("add_ovf", ovf, 0);

        start_op(OP_SUB, 32'h8000_0000, 32'h1);
        wait_done(1'b0, n);
        chk("sub_res", res, 32'h7FFF_FFFF);
        chk("sub_ovf", ovf, 1);
        chk("sub_carry", cout, 0);

        start_op(OP_SLTU, 32'd3, 32'd5);
        wait_done(1'b0, n);
        chk("sltu_res", res, 1);

        start_op(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1'b0, n);
        chk("mul_lat", n, 33);
        chk("mul_hi", hi, 32'hFFFF_FFFE);
        chk("mul_res", res, 32'h1);

        start_op(OP_DIVU, 32'd100, 32'd7);
        wait_done(1'b0, n);
        chk("div_lat", n, 33);
        chk("div_res", res, 14);
        chk("div_hi", hi, 2);

        start_op(OP_DIVU, 32'd5, 32'd0);
        wait_done(1'b0, n);
        chk("div0_lat", n, 1);
        chk("div0_res", res, 32'hFFFF_FFFF);
        chk("div0_hi", hi, 5);
        chk("div0_flag", dz, 1);

        start_op(OP_MULU, 32'h1234_5678, 32'h10);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(1'b0, n);
        chk("mid_res", res, 32'h2345_6780);
        chk("mid_hi", hi, 32'h1);

        start_op(OP_MULU, 32'h0000_FFFF, 32'h0000_FFFF);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_result", res, 0);
        chk("abort_hi", hi, 0);
        chk("abort_zero", zero, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_nodone", done, 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        start_op(OP_ADD, 32'd2, 32'd3);
        wait_done(1'b0, n);
        chk("post_rst_lat", n, 1);
        chk("post_rst_res", res, 5);

        for (int c = 0; c < 2500; c++) begin
            @(posedge clk); #1;
            start = ($urandom % 4) == 0;
            op = 3'($urandom % 8);
            a = rnd();
            b = rnd();
            if (c == 1200) rst_n = 1'b0;
            if (c == 1203) rst_n = 1'b1;
        end
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
